// File: rtl/scan_chain_ctrl_if.sv
// Pattern-in / response-out stream bundle for scan_chain_ctrl.
// master is the controller side; slave is the producer/consumer side.
interface scan_chain_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;

    modport master (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );
endinterface

// File: rtl/scan_chain_ctrl.sv
// Scan test controller: buffers a DEPTH-word pattern, shifts it into the chain, captures once,
// unloads the response and streams it out. out_valid rises on the (2*DEPTH+2)-th rising edge
// after the edge that accepts the last pattern word.
module scan_chain_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    scan_chain_ctrl_if.master bus,
    output logic             scan_se,
    output logic [WIDTH-1:0] scan_si,
    input  logic [WIDTH-1:0] scan_so,
    output logic             busy,
    output logic             done
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        LOAD,
        SHIFT_IN,
        CAPTURE,
        UNLOAD,
        DRAIN
    } state_t;

    state_t           state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [WIDTH-1:0] pat_buf [DEPTH];
    logic             buf_we;
    logic [WIDTH-1:0] buf_wdata;
    logic             se_n;
    logic [WIDTH-1:0] si_n;
    logic             in_ready_q, in_ready_n;
    logic             out_valid_q, out_valid_n;
    logic             done_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= LOAD;
            idx         <= '0;
            scan_se     <= 1'b0;
            scan_si     <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            scan_se     <= se_n;
            scan_si     <= si_n;
            in_ready_q  <= in_ready_n;
            out_valid_q <= out_valid_n;
            done        <= done_n;
            busy        <= (state_n != LOAD);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) pat_buf[i] <= '0;
        end else if (buf_we) begin
            pat_buf[idx] <= buf_wdata;
        end
    end

    // In UNLOAD the first cycle only raises se; the chain's capture edge happens there.
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        buf_we      = 1'b0;
        buf_wdata   = bus.in_data;
        se_n        = scan_se;
        si_n        = scan_si;
        in_ready_n  = 1'b0;
        out_valid_n = out_valid_q;
        done_n      = 1'b0;
        case (state)
            LOAD: begin
                in_ready_n = 1'b1;
                if (bus.in_valid && in_ready_q) begin
                    buf_we = 1'b1;
                    idx_n  = idx + 1'b1;
                    if (idx == LAST) begin
                        idx_n      = '0;
                        in_ready_n = 1'b0;
                        state_n    = SHIFT_IN;
                    end
                end
            end
            SHIFT_IN: begin
                se_n  = 1'b1;
                si_n  = pat_buf[idx];
                idx_n = idx + 1'b1;
                if (idx == LAST) begin
                    idx_n   = '0;
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                se_n    = 1'b0;
                si_n    = '0;
                state_n = UNLOAD;
            end
            UNLOAD: begin
                se_n = 1'b1;
                if (scan_se) begin
                    buf_we    = 1'b1;
                    buf_wdata = scan_so;
                    idx_n     = idx + 1'b1;
                    if (idx == LAST) begin
                        idx_n       = '0;
                        se_n        = 1'b0;
                        out_valid_n = 1'b1;
                        state_n     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready) begin
                    idx_n = idx + 1'b1;
                    if (idx == LAST) begin
                        idx_n       = '0;
                        out_valid_n = 1'b0;
                        done_n      = 1'b1;
                        in_ready_n  = 1'b1;
                        state_n     = LOAD;
                    end
                end
            end
            default: state_n = LOAD;
        endcase
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = pat_buf[idx];
endmodule
